// File: rtl/prog_loader.sv
// Streams program bytes into 32-bit little-endian words and writes them to a TCM port.
// Partial last words carry only the valid lanes; a write past the top address aborts with err.
module prog_loader #(
  parameter int MEM_AW = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [MEM_AW-1:0] base_addr,
  input  logic [MEM_AW+1:0] byte_len,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} stateT;

  localparam logic [MEM_AW+1:0] LEN_ONE  = {{(MEM_AW+1){1'b0}}, 1'b1};
  localparam logic [MEM_AW-1:0] ADDR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};

  stateT             state, stateNext;
  logic [MEM_AW+1:0] remaining, remainingNext;
  logic [1:0]        laneIdx, laneIdxNext;
  logic [MEM_AW-1:0] addrNext;
  logic [31:0]       wdataNext;
  logic [3:0]        beNext;
  logic              errNext;

  // Every output is a flop; the combinational block only decides what they become next.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      remaining <= '0;
      laneIdx   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      err       <= 1'b0;
      s_ready   <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= stateNext;
      remaining <= remainingNext;
      laneIdx   <= laneIdxNext;
      mem_addr  <= addrNext;
      mem_wdata <= wdataNext;
      mem_be    <= beNext;
      err       <= errNext;
      s_ready   <= (stateNext == COLLECT);
      mem_we    <= (stateNext == WRITE);
      busy      <= (stateNext != IDLE);
      done      <= (stateNext == DONE);
    end
  end

  always_comb begin
    stateNext     = state;
    remainingNext = remaining;
    laneIdxNext   = laneIdx;
    addrNext      = mem_addr;
    wdataNext     = mem_wdata;
    beNext        = mem_be;
    errNext       = err;

    case (state)
      IDLE: begin
        if (start) begin
          errNext     = 1'b0;
          laneIdxNext = '0;
          wdataNext   = '0;
          beNext      = '0;
          if (byte_len != '0) begin
            addrNext      = base_addr;
            remainingNext = byte_len;
            stateNext     = COLLECT;
          end else begin
            stateNext = DONE;
          end
        end
      end

      COLLECT: begin
        if (s_valid && s_ready) begin
          wdataNext[{laneIdx, 3'b000} +: 8] = s_data;
          beNext[laneIdx]                   = 1'b1;
          laneIdxNext                       = laneIdx + 2'd1;
          remainingNext                     = remaining - LEN_ONE;
          if (laneIdx == 2'd3 || remaining == LEN_ONE) begin
            stateNext = WRITE;
          end
        end
      end

      // The top address is the last one we may write; more data left means overflow.
      WRITE: begin
        if (mem_ack) begin
          wdataNext   = '0;
          beNext      = '0;
          laneIdxNext = '0;
          addrNext    = mem_addr + ADDR_ONE;
          if (remaining == '0) begin
            stateNext = DONE;
          end else if (mem_addr == '1) begin
            errNext   = 1'b1;
            stateNext = DONE;
          end else begin
            stateNext = COLLECT;
          end
        end
      end

      DONE: begin
        stateNext = IDLE;
      end

      default: begin
        stateNext = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed vector table, hand-written corner
// sequences, and randomized loads compared against a word-packing reference model.
module tb_prog_loader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [11:0] base_addr;
  logic [13:0] byte_len;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err;

  prog_loader #(.MEM_AW(12)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .byte_len  (byte_len),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } writeT;

  typedef struct {
    logic [11:0] base;
    logic [13:0] len;
    logic [63:0] bytes;
    int          ackDelay;
    int          expWrites;
    logic [31:0] expData0;
    logic [31:0] expData1;
    logic [3:0]  expBe0;
    logic [3:0]  expBe1;
    logic        expErr;
  } vecT;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  streamQ[$];
  writeT       writeQ[$];
  writeT       expQ[$];
  logic        expErr;
  logic        errAtDone;
  bit          doneSeen;
  bit          holdBroken;
  bit          busyDropped;
  vecT         vecs[8];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Runs one load from start to the done pulse, streaming streamQ and logging acked writes.
  task automatic applyStimulus(input logic [11:0] base, input logic [13:0] len,
                               input int ackDelay, input int validPct, input bit noise);
    int cycles = 0;
    int byteIdx = 0;
    int waitCnt = 0;
    bit ackedLast = 0;
    logic [11:0] hA;
    logic [31:0] hD;
    logic [3:0]  hB;
    writeQ.delete();
    doneSeen = 0;
    holdBroken = 0;
    busyDropped = 0;
    errAtDone = 0;
    @(negedge clk);
    start = 1'b1;
    base_addr = base;
    byte_len = len;
    s_valid = 1'b0;
    mem_ack = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!doneSeen && cycles < 3000) begin
      if (!busy) busyDropped = 1;
      if (done) begin
        doneSeen = 1;
        errAtDone = err;
      end
      if (mem_we) begin
        if (s_ready || ackedLast) holdBroken = 1;
        if (waitCnt == 0) {hA, hD, hB} = {mem_addr, mem_wdata, mem_be};
        else if ({hA, hD, hB} !== {mem_addr, mem_wdata, mem_be}) holdBroken = 1;
        waitCnt++;
      end else if (waitCnt != 0) begin
        holdBroken = 1;
      end
      mem_ack = mem_we ? (waitCnt > ackDelay) : (noise && $urandom_range(0, 3) == 0);
      ackedLast = mem_we && mem_ack;
      if (ackedLast) begin
        writeQ.push_back('{mem_addr, mem_wdata, mem_be, cycles});
        waitCnt = 0;
      end
      if (noise && !doneSeen) begin
        start = ($urandom_range(0, 7) == 0);
        base_addr = 12'($urandom);
        byte_len = 14'($urandom);
      end else begin
        start = 1'b0;
      end
      if (byteIdx < streamQ.size() && !doneSeen) begin
        s_valid = ($urandom_range(1, 100) <= validPct);
        s_data = streamQ[byteIdx];
      end else begin
        s_valid = 1'b0;
        s_data = 8'($urandom);
      end
      if (s_valid && s_ready) byteIdx++;
      @(negedge clk);
      cycles++;
    end
    start = 1'b0;
    s_valid = 1'b0;
    mem_ack = 1'b0;
    checkOutput("load finished", 64'(doneSeen), 64'd1);
    checkOutput("done single pulse", 64'(done), 64'd0);
    checkOutput("idle after done", 64'(busy), 64'd0);
    checkOutput("busy during load", 64'(busyDropped), 64'd0);
    checkOutput("write hold stable", 64'(holdBroken), 64'd0);
  endtask

  // Reference: chop the byte list into 4-byte little-endian words at consecutive addresses,
  // stopping (with overflow) once an address would pass the top of the 12-bit space.
  task automatic buildExpected(input logic [11:0] base, input logic [13:0] len);
    int nw = (int'(len) + 3) / 4;
    expQ.delete();
    expErr = 1'b0;
    for (int w = 0; w < nw; w++) begin
      int a = int'(base) + w;
      writeT e;
      if (a > 4095) begin
        expErr = 1'b1;
        break;
      end
      e.addr = 12'(a);
      e.data = '0;
      e.be = '0;
      e.cyc = 0;
      for (int l = 0; l < 4; l++) begin
        if (4 * w + l < int'(len)) begin
          e.data[8 * l +: 8] = streamQ[4 * w + l];
          e.be[l] = 1'b1;
        end
      end
      expQ.push_back(e);
    end
  endtask

  task automatic compareWrites(input string tag);
    checkOutput({tag, " write count"}, 64'(writeQ.size()), 64'(expQ.size()));
    for (int w = 0; w < writeQ.size() && w < expQ.size(); w++) begin
      checkOutput({tag, " addr"}, 64'(writeQ[w].addr), 64'(expQ[w].addr));
      checkOutput({tag, " wdata"}, 64'(writeQ[w].data), 64'(expQ[w].data));
      checkOutput({tag, " be"}, 64'(writeQ[w].be), 64'(expQ[w].be));
    end
  endtask

  initial begin
    logic [63:0] bytesTmp;
    logic [11:0] rBase;
    logic [13:0] rLen;

    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    byte_len = '0;
    s_data = '0;
    s_valid = 1'b0;
    mem_ack = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset s_ready", 64'(s_ready), 64'd0);
    checkOutput("reset mem_we", 64'(mem_we), 64'd0);
    checkOutput("reset mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("reset mem_be", 64'(mem_be), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post-reset busy", 64'(busy), 64'd0);

    vecs[0] = '{12'h010, 14'd8, 64'h0000006F_00000013, 0, 2, 32'h00000013, 32'h0000006F, 4'hF, 4'hF, 1'b0};
    vecs[1] = '{12'h020, 14'd6, 64'h00001615_14131211, 0, 2, 32'h14131211, 32'h00001615, 4'hF, 4'h3, 1'b0};
    vecs[2] = '{12'h040, 14'd6, 64'h00001615_14131211, 3, 2, 32'h14131211, 32'h00001615, 4'hF, 4'h3, 1'b0};
    vecs[3] = '{12'hFFF, 14'd8, 64'h88776655_44332211, 0, 1, 32'h44332211, 32'h00000000, 4'hF, 4'h0, 1'b1};
    vecs[4] = '{12'h100, 14'd0, 64'h0, 0, 0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0};
    vecs[5] = '{12'h005, 14'd1, 64'hA5, 1, 1, 32'h000000A5, 32'h0, 4'h1, 4'h0, 1'b0};
    vecs[6] = '{12'h006, 14'd4, 64'hDEADBEEF, 2, 1, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0, 1'b0};
    vecs[7] = '{12'hFFE, 14'd5, 64'h00000005_04030201, 0, 2, 32'h04030201, 32'h00000005, 4'hF, 4'h1, 1'b0};

    for (int v = 0; v < 8; v++) begin
      streamQ.delete();
      bytesTmp = vecs[v].bytes;
      for (int i = 0; i < int'(vecs[v].len); i++) streamQ.push_back(bytesTmp[8 * i +: 8]);
      applyStimulus(vecs[v].base, vecs[v].len, vecs[v].ackDelay, 100, 1'b0);
      expQ.delete();
      for (int w = 0; w < vecs[v].expWrites; w++) begin
        expQ.push_back('{12'(vecs[v].base + 12'(w)),
                         (w == 0) ? vecs[v].expData0 : vecs[v].expData1,
                         (w == 0) ? vecs[v].expBe0 : vecs[v].expBe1, 0});
      end
      compareWrites($sformatf("vec%0d", v));
      checkOutput($sformatf("vec%0d err at done", v), 64'(errAtDone), 64'(vecs[v].expErr));
      checkOutput($sformatf("vec%0d err sticky", v), 64'(err), 64'(vecs[v].expErr));
    end

    // Back-to-back full words with immediate ack must come out every 5 cycles.
    streamQ.delete();
    for (int i = 0; i < 12; i++) streamQ.push_back(8'(i + 8'h40));
    applyStimulus(12'h200, 14'd12, 0, 100, 1'b0);
    checkOutput("throughput write count", 64'(writeQ.size()), 64'd3);
    for (int w = 1; w < writeQ.size(); w++) begin
      checkOutput("throughput spacing", 64'(writeQ[w].cyc - writeQ[w - 1].cyc), 64'd5);
    end

    // Reset while a write is waiting for ack, then an empty load.
    @(negedge clk);
    start = 1'b1;
    base_addr = 12'h030;
    byte_len = 14'd4;
    @(negedge clk);
    start = 1'b0;
    s_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s_data = 8'(8'hC0 + i);
      @(negedge clk);
    end
    s_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("awaiting ack mem_we", 64'(mem_we), 64'd1);
    checkOutput("awaiting ack wdata", 64'(mem_wdata), 64'hC3C2C1C0);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("abort mem_we", 64'(mem_we), 64'd0);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("abort mem_wdata", 64'(mem_wdata), 64'd0);
    checkOutput("abort mem_be", 64'(mem_be), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("after abort mem_we", 64'(mem_we), 64'd0);
    checkOutput("after abort done", 64'(done), 64'd0);
    streamQ.delete();
    applyStimulus(12'h123, 14'd0, 0, 100, 1'b0);
    checkOutput("empty load writes", 64'(writeQ.size()), 64'd0);

    // Randomized loads with stalls, late acks, spurious acks and ignored start pulses.
    for (int n = 0; n < 40; n++) begin
      rBase = ($urandom_range(0, 3) == 0) ? 12'(12'hFFF - 12'($urandom_range(0, 6))) : 12'($urandom);
      rLen = 14'($urandom_range(0, 40));
      streamQ.delete();
      for (int i = 0; i < int'(rLen); i++) streamQ.push_back(8'($urandom));
      applyStimulus(rBase, rLen, $urandom_range(0, 3), $urandom_range(30, 100), 1'b1);
      buildExpected(rBase, rLen);
      compareWrites($sformatf("rnd%0d", n));
      checkOutput($sformatf("rnd%0d err", n), 64'(errAtDone), 64'(expErr));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
